// File: rtl/instr_mem_loadable_if.sv
// Fetch and program-load bus of the loadable instruction memory.
// The master is the fetch stage plus loader; the slave is the memory.
interface instr_mem_loadable_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_fault;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   prog_len;

  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
    input  fetch_data, fetch_valid, fetch_fault, load_ready, load_done, prog_len
  );

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_last,
    output fetch_data, fetch_valid, fetch_fault, load_ready, load_done, prog_len
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Synchronous instruction memory with a streaming program loader.
// Fetches complete one cycle after the request; fetches that fault or arrive while busy return NOP.
module instr_mem_loadable #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 256,
  parameter bit                BYTE_ADDR = 1'b0,
  parameter logic [DATA_W-1:0] NOP       = '0
) (
  input logic clock,
  input logic reset,
  instr_mem_loadable_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state;
  state_t            state_next;
  logic              write_en;
  logic              finish;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W:0]   prog_len;
  logic              load_done;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_fault;
  logic [ADDR_W-1:0] widx;
  logic              misaligned;
  logic              fault;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A load ends on the word flagged last or when the array is full, whichever comes first.
  always_comb begin
    state_next = state;
    write_en   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_start) state_next = LOAD;
      end
      LOAD: begin
        if (bus.load_valid) begin
          write_en = 1'b1;
          if (bus.load_last || (wr_ptr == LAST_PTR)) begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      prog_len  <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= finish;
      if ((state == IDLE) && bus.load_start) begin
        wr_ptr   <= '0;
        prog_len <= '0;
      end else if (write_en) begin
        if (finish) prog_len <= (ADDR_W+1)'(wr_ptr) + (ADDR_W+1)'(1);
        else        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
    end
  end

  // Storage is deliberately never cleared; prog_len alone decides which words are fetchable.
  always_ff @(posedge clock) begin
    if (write_en && !reset) mem[wr_ptr] <= bus.load_data;
  end

  assign widx       = BYTE_ADDR ? (bus.fetch_addr >> 2) : bus.fetch_addr;
  assign misaligned = BYTE_ADDR && (bus.fetch_addr[1:0] != 2'b00);
  assign fault      = (state == LOAD) || ({1'b0, widx} >= prog_len) || misaligned;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_data  <= NOP;
    end else begin
      fetch_valid <= bus.fetch_req;
      if (bus.fetch_req) begin
        fetch_fault <= fault;
        fetch_data  <= fault ? NOP : mem[PTR_W'(widx)];
      end else begin
        fetch_fault <= 1'b0;
      end
    end
  end

  assign bus.fetch_data  = fetch_data;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_fault = fetch_fault;
  assign bus.load_ready  = (state == LOAD);
  assign bus.load_done   = load_done;
  assign bus.prog_len    = prog_len;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: three instances (word-addressed, DEPTH=4, byte-addressed)
// checked every cycle against a behavioural model, plus hand-computed spot checks.
module tb_instr_mem_loadable;

  localparam int N = 3;
  localparam logic [31:0] NOP = 32'h0;
  localparam logic [31:0] PROG [5] = '{32'h8C0100FF, 32'hAC010009, 32'h8C020009,
                                       32'hAC0200FF, 32'h08000000};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        fetch_req  [N];
  logic [7:0]  fetch_addr [N];
  logic        load_start [N];
  logic        load_valid [N];
  logic [31:0] load_data  [N];
  logic        load_last  [N];
  logic [31:0] dut_data   [N];
  logic        dut_valid  [N];
  logic        dut_fault  [N];
  logic        dut_ready  [N];
  logic        dut_done   [N];
  logic [8:0]  dut_len    [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    instr_mem_loadable_if #(.DATA_W(32), .ADDR_W(8)) bus ();
    assign bus.fetch_req  = fetch_req[g];
    assign bus.fetch_addr = fetch_addr[g];
    assign bus.load_start = load_start[g];
    assign bus.load_valid = load_valid[g];
    assign bus.load_data  = load_data[g];
    assign bus.load_last  = load_last[g];
    assign dut_data[g]    = bus.fetch_data;
    assign dut_valid[g]   = bus.fetch_valid;
    assign dut_fault[g]   = bus.fetch_fault;
    assign dut_ready[g]   = bus.load_ready;
    assign dut_done[g]    = bus.load_done;
    assign dut_len[g]     = bus.prog_len;

    instr_mem_loadable #(
      .DATA_W(32), .ADDR_W(8),
      .DEPTH((g == 1) ? 4 : 256),
      .BYTE_ADDR(g == 2),
      .NOP(NOP)
    ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
    );
  end

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  function automatic int depth_of(int k);
    return (k == 1) ? 4 : 256;
  endfunction

  function automatic bit byte_mode(int k);
    return (k == 2);
  endfunction

  // Behavioural model: a program is a list of words plus its length; loading is a flag.
  logic [31:0] m_mem [N][256];
  int          m_len [N];
  int          m_ptr [N];
  bit          m_loading [N];
  logic [31:0] exp_data  [N];
  logic        exp_valid [N];
  logic        exp_fault [N];
  logic        exp_done  [N];
  int          widx;
  bit          bad;

  always @(posedge clock) begin
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        exp_valid[k] = 1'b0;
        exp_fault[k] = 1'b0;
        exp_data[k]  = NOP;
        exp_done[k]  = 1'b0;
        m_len[k]     = 0;
        m_ptr[k]     = 0;
        m_loading[k] = 1'b0;
      end else begin
        exp_valid[k] = fetch_req[k];
        exp_fault[k] = 1'b0;
        if (fetch_req[k]) begin
          widx = byte_mode(k) ? int'(fetch_addr[k]) / 4 : int'(fetch_addr[k]);
          bad  = m_loading[k] || (widx >= m_len[k]) ||
                 (byte_mode(k) && (int'(fetch_addr[k]) % 4 != 0));
          exp_fault[k] = bad;
          exp_data[k]  = bad ? NOP : m_mem[k][widx];
        end
        exp_done[k] = 1'b0;
        if (m_loading[k]) begin
          if (load_valid[k]) begin
            m_mem[k][m_ptr[k]] = load_data[k];
            if (load_last[k] || (m_ptr[k] == depth_of(k) - 1)) begin
              m_len[k]     = m_ptr[k] + 1;
              m_loading[k] = 1'b0;
              exp_done[k]  = 1'b1;
            end else begin
              m_ptr[k]++;
            end
          end
        end else if (load_start[k]) begin
          m_loading[k] = 1'b1;
          m_ptr[k]     = 0;
          m_len[k]     = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s[%0d] at %0t: got %h, expected %h", name, k, $time, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      for (int k = 0; k < N; k++) begin
        checkOutput("fetch_valid", k, 32'(dut_valid[k]), 32'(exp_valid[k]));
        checkOutput("fetch_fault", k, 32'(dut_fault[k]), 32'(exp_fault[k]));
        checkOutput("fetch_data",  k, dut_data[k], exp_data[k]);
        checkOutput("load_ready",  k, 32'(dut_ready[k]), 32'(m_loading[k]));
        checkOutput("load_done",   k, 32'(dut_done[k]), 32'(exp_done[k]));
        checkOutput("prog_len",    k, 32'(dut_len[k]), 32'(m_len[k]));
      end
    end
  end

  task automatic applyStimulus(input int k, input bit req, input logic [7:0] addr,
                               input bit start, input bit valid,
                               input logic [31:0] data, input bit last);
    fetch_req[k]  = req;
    fetch_addr[k] = addr;
    load_start[k] = start;
    load_valid[k] = valid;
    load_data[k]  = data;
    load_last[k]  = last;
  endtask

  task automatic idleAll();
    for (int k = 0; k < N; k++) applyStimulus(k, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic stepCycle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    idleAll();
    reset   = 1'b1;
    started = 1'b1;
    stepCycle();
    stepCycle();
    reset = 1'b0;

    // Fetch from an empty program faults with NOP.
    for (int k = 0; k < N; k++) applyStimulus(k, 1'b1, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    stepCycle();
    checkOutput("empty_valid", 0, 32'(dut_valid[0]), 32'd1);
    checkOutput("empty_fault", 0, 32'(dut_fault[0]), 32'd1);
    checkOutput("empty_data",  0, dut_data[0], 32'h0);
    checkOutput("empty_len",   0, 32'(dut_len[0]), 32'd0);

    // Load the 5-word program into all three; instance 1 fills at 4 words.
    idleAll();
    for (int k = 0; k < N; k++) load_start[k] = 1'b1;
    stepCycle();
    for (int i = 0; i < 5; i++) begin
      idleAll();
      for (int k = 0; k < N; k++)
        applyStimulus(k, 1'b0, 8'd0, 1'b0, 1'b1, PROG[i], i == 4);
      if (i == 1) fetch_req[0] = 1'b1;
      if (i == 2) load_start[0] = 1'b1;
      stepCycle();
      if (i == 1) checkOutput("load_fetch_fault", 0, 32'(dut_fault[0]), 32'd1);
    end
    idleAll();
    checkOutput("done_pulse", 0, 32'(dut_done[0]), 32'd1);
    checkOutput("len_five",   0, 32'(dut_len[0]), 32'd5);
    checkOutput("len_full",   1, 32'(dut_len[1]), 32'd4);

    for (int i = 0; i < 6; i++) begin
      idleAll();
      applyStimulus(0, 1'b1, 8'(i), 1'b0, 1'b0, 32'd0, 1'b0);
      stepCycle();
      checkOutput("prog_fault", 0, 32'(dut_fault[0]), (i == 5) ? 32'd1 : 32'd0);
      checkOutput("prog_word",  0, dut_data[0], (i == 5) ? 32'h0 : PROG[i]);
    end

    idleAll();
    applyStimulus(2, 1'b1, 8'd8, 1'b0, 1'b0, 32'd0, 1'b0);
    stepCycle();
    checkOutput("byte_word", 2, dut_data[2], 32'h8C020009);
    applyStimulus(2, 1'b1, 8'd6, 1'b0, 1'b0, 32'd0, 1'b0);
    stepCycle();
    checkOutput("byte_misaligned", 2, 32'(dut_fault[2]), 32'd1);

    // Six words with no last marker into the 4-deep instance.
    idleAll();
    load_start[1] = 1'b1;
    stepCycle();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1'b0, 8'd0, 1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0);
      stepCycle();
    end
    idleAll();
    checkOutput("auto_len", 1, 32'(dut_len[1]), 32'd4);
    applyStimulus(1, 1'b1, 8'd3, 1'b0, 1'b0, 32'd0, 1'b0);
    stepCycle();
    checkOutput("auto_word", 1, dut_data[1], 32'hA000_0003);

    // Reset in the middle of a load.
    idleAll();
    load_start[0] = 1'b1;
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b0, 8'd0, 1'b0, 1'b1, PROG[i], 1'b0);
      stepCycle();
    end
    idleAll();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("abort_len", 0, 32'(dut_len[0]), 32'd0);
    applyStimulus(0, 1'b1, 8'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    stepCycle();
    checkOutput("abort_fault", 0, 32'(dut_fault[0]), 32'd1);

    // Randomised traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < N; k++)
        applyStimulus(k, $urandom_range(0, 2) != 0,
                      8'($urandom_range(0, (k == 2) ? 40 : 12)),
                      $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                      $urandom, $urandom_range(0, 7) == 0);
      stepCycle();
    end
    reset = 1'b0;
    idleAll();
    stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
